// File: rtl/stepper_pulse_gen.sv
// Multi-channel stepper step/direction pulse generator with per-channel FSMs.
// Define STEPPER_POS_EN to add per-channel signed position counters (pos / pos_clr).
module stepper_pulse_gen #(
  parameter  int CHANNELS  = 5,
  parameter  int CNT_W     = 31,
  parameter  int DIV_W     = 32,
  parameter  int PULSE_W   = 2,
  parameter  int DIR_SETUP = 2,
  parameter  int POS_W     = 32,
  localparam int CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [CHAN_W-1:0]         cmd_chan,
  input  logic [CNT_W-1:0]          cmd_steps,
  input  logic [DIV_W-1:0]          cmd_period,
  input  logic                      cmd_dir,
  input  logic [CHANNELS-1:0]       abort,
`ifdef STEPPER_POS_EN
  output logic [CHANNELS*POS_W-1:0] pos,
  input  logic [CHANNELS-1:0]       pos_clr,
`endif
  output logic [CHANNELS-1:0]       step,
  output logic [CHANNELS-1:0]       dir,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_FIN
  } state_t;

  localparam logic [DIV_W-1:0] MIN_PERIOD = DIV_W'(PULSE_W + 1);
  localparam logic [DIV_W-1:0] PW_M1      = DIV_W'(PULSE_W - 1);
  localparam logic [DIV_W-1:0] SETUP_M1   = DIV_W'(DIR_SETUP - 1);
  localparam logic [DIV_W-1:0] CNT_ONE    = DIV_W'(1);
  localparam logic [CNT_W-1:0] REM_ONE    = CNT_W'(1);

  // Shorter periods would leave no low phase after the step pulse.
  logic [DIV_W-1:0] eff_period;
  assign eff_period = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;

  // Out-of-range channels keep ready high so their commands drain away.
  always_comb begin
    cmd_ready = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      if (cmd_chan == CHAN_W'(c)) cmd_ready = ~busy[c];
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             step_q, busy_q, done_q;
    logic             accept;

    assign accept = cmd_valid && cmd_ready && (cmd_chan == CHAN_W'(i));

    always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      rem_d    = rem_q;
      dir_d    = dir_q;
      unique case (state_q)
        ST_IDLE, ST_FIN: begin
          state_d = ST_IDLE;
          if (accept) begin
            dir_d    = cmd_dir;
            period_d = eff_period;
            rem_d    = cmd_steps;
            cnt_d    = SETUP_M1;
            state_d  = (cmd_steps != '0) ? ST_SETUP : ST_FIN;
          end
        end
        ST_SETUP: begin
          if (cnt_q == '0) begin
            state_d = ST_HIGH;
            cnt_d   = PW_M1;
            rem_d   = rem_q - REM_ONE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (cnt_q == '0) begin
            state_d = ST_LOW;
            cnt_d   = period_q - MIN_PERIOD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_LOW: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end else if (rem_q != '0) begin
            state_d = ST_HIGH;
            cnt_d   = PW_M1;
            rem_d   = rem_q - REM_ONE;
          end else begin
            state_d = ST_FIN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // Abort overrides everything, including a same-cycle accept.
      if (abort[i]) begin
        state_d = ST_IDLE;
        dir_d   = dir_q;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q  <= ST_IDLE;
        cnt_q    <= '0;
        period_q <= '0;
        rem_q    <= '0;
        dir_q    <= 1'b0;
        step_q   <= 1'b0;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        period_q <= period_d;
        rem_q    <= rem_d;
        dir_q    <= dir_d;
        step_q   <= (state_d == ST_HIGH);
        busy_q   <= (state_d == ST_SETUP) || (state_d == ST_HIGH) || (state_d == ST_LOW);
        done_q   <= (state_d == ST_FIN);
      end
    end

    assign step[i] = step_q;
    assign dir[i]  = dir_q;
    assign busy[i] = busy_q;
    assign done[i] = done_q;

`ifdef STEPPER_POS_EN
    logic [POS_W-1:0] pos_q;
    logic             rise;

    // Count on the same edge that raises step, so pos tracks the pin.
    assign rise = (state_d == ST_HIGH) && (state_q != ST_HIGH);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pos_q <= '0;
      end else if (pos_clr[i]) begin
        pos_q <= '0;
      end else if (rise) begin
        pos_q <= dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
      end
    end

    assign pos[i*POS_W +: POS_W] = pos_q;
`endif
  end

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Directed self-checking bench for stepper_pulse_gen with hand-derived timing.
// Position checks are active when STEPPER_POS_EN is defined.
module tb_stepper_pulse_gen;

  localparam int CH     = 5;
  localparam int CNT_W  = 31;
  localparam int DIV_W  = 32;
  localparam int PW     = 2;
  localparam int DS     = 2;
  localparam int POS_W  = 32;
  localparam int CHAN_W = 3;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [CHAN_W-1:0]   cmd_chan;
  logic [CNT_W-1:0]    cmd_steps;
  logic [DIV_W-1:0]    cmd_period;
  logic                cmd_dir;
  logic [CH-1:0]       abort;
  logic [CH-1:0]       step, dir, busy, done;
`ifdef STEPPER_POS_EN
  logic [CH*POS_W-1:0] pos;
  logic [CH-1:0]       pos_clr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [CH-1:0]    step_tr [128];
  logic [CH-1:0]    busy_tr [128];
  logic [CH-1:0]    done_tr [128];
  logic [CH-1:0]    dir_tr  [128];
  logic [POS_W-1:0] exp_pos [CH];

  stepper_pulse_gen #(
    .CHANNELS (CH),
    .CNT_W    (CNT_W),
    .DIV_W    (DIV_W),
    .PULSE_W  (PW),
    .DIR_SETUP(DS),
    .POS_W    (POS_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_chan  (cmd_chan),
    .cmd_steps (cmd_steps),
    .cmd_period(cmd_period),
    .cmd_dir   (cmd_dir),
    .abort     (abort),
`ifdef STEPPER_POS_EN
    .pos       (pos),
    .pos_clr   (pos_clr),
`endif
    .step      (step),
    .dir       (dir),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_pos(input string tag);
`ifdef STEPPER_POS_EN
    for (int c = 0; c < CH; c++)
      check($sformatf("%s_pos%0d", tag, c), pos[c*POS_W +: POS_W], exp_pos[c]);
`endif
  endtask

  // Reference timeline: cycle 0 = accept, first rise at 1+DS, rises every p, done after last low.
  function automatic logic [127:0] exp_vec(input int kind, input int steps, input int per, input int n);
    logic [127:0] v;
    int p, fin;
    v   = '0;
    p   = (per < PW + 1) ? PW + 1 : per;
    fin = (steps == 0) ? 1 : 1 + DS + steps * p;
    for (int k = 0; k < n; k++) begin
      case (kind)
        0:       v[k] = (k >= 1 + DS) && (k < fin) && (((k - 1 - DS) % p) < PW);
        1:       v[k] = (steps != 0) && (k >= 1) && (k < fin);
        default: v[k] = (k == fin);
      endcase
    end
    return v;
  endfunction

  function automatic logic [127:0] col(input int kind, input int ch, input int n);
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < n; k++) begin
      case (kind)
        0:       v[k] = step_tr[k][ch];
        1:       v[k] = busy_tr[k][ch];
        default: v[k] = done_tr[k][ch];
      endcase
    end
    return v;
  endfunction

  // Presents one command during a single cycle; returns just after the accepting edge.
  task automatic send(input int ch, input logic [CNT_W-1:0] steps, input logic [DIV_W-1:0] per,
                      input logic d);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_chan   = CHAN_W'(ch);
    cmd_steps  = steps;
    cmd_period = per;
    cmd_dir    = d;
    #1;
    check($sformatf("ready_ch%0d", ch), cmd_ready, 1);
    step_tr[0] = step; busy_tr[0] = busy; done_tr[0] = done; dir_tr[0] = dir;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_move(input string tag, input int ch, input int steps, input int per,
                          input logic d, input int n);
    send(ch, CNT_W'(steps), DIV_W'(per), d);
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      step_tr[k] = step; busy_tr[k] = busy; done_tr[k] = done; dir_tr[k] = dir;
    end
    check({tag, "_step"}, col(0, ch, n), exp_vec(0, steps, per, n));
    check({tag, "_busy"}, col(1, ch, n), exp_vec(1, steps, per, n));
    check({tag, "_done"}, col(2, ch, n), exp_vec(2, steps, per, n));
    check({tag, "_dir"}, dir_tr[1][ch], d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, edges, cyc10;
    logic prev, seen;

    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_chan   = '0;
    cmd_steps  = '0;
    cmd_period = '0;
    cmd_dir    = 1'b0;
    abort      = '0;
`ifdef STEPPER_POS_EN
    pos_clr    = '0;
`endif
    for (int c = 0; c < CH; c++) exp_pos[c] = '0;

    #2;
    check("reset_outputs", {step, dir, busy, done}, 0);
    check_pos("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 check("ready_after_reset", cmd_ready, 1);

    // Channel 0: three steps, period 10, positive.
    run_move("ch0_basic", 0, 3, 10, 1'b1, 40);
    exp_pos[0] = 32'd3;
    check_pos("ch0_basic");

    // Channel 2: zero steps completes immediately without a pulse.
    run_move("ch2_zero", 2, 0, 10, 1'b1, 6);

    // Channel 1: period below minimum is stretched to PW+1.
    run_move("ch1_minper", 1, 5, 1, 1'b0, 24);
    exp_pos[1] = 32'hFFFF_FFFB;
    check_pos("ch1_minper");

    // Busy channel stalls; another channel is accepted meanwhile.
    send(0, CNT_W'(2), DIV_W'(4), 1'b1);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_chan = 3'd0; cmd_steps = CNT_W'(1); cmd_period = DIV_W'(3); cmd_dir = 1'b0;
    #1 check("ready_ch0_busy", cmd_ready, 0);
    @(negedge clk);
    cmd_chan = 3'd3; cmd_steps = CNT_W'(3); cmd_period = DIV_W'(5); cmd_dir = 1'b0;
    #1 check("ready_ch3_free", cmd_ready, 1);
    @(negedge clk);
    cmd_chan = 3'd0; cmd_steps = CNT_W'(1); cmd_period = DIV_W'(3); cmd_dir = 1'b0;
    #1 check("both_busy", busy, 5'b01001);
    w = 3;
    while (!cmd_ready && w < 60) begin
      @(negedge clk);
      #1 w++;
    end
    check("ch0_ready_at_fin", w, 11);
    check("ch0_done_at_fin", done, 5'b00001);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("ch0_second_dir", dir[0], 0);
    check("ch0_second_busy", busy[0], 1);
    repeat (5) @(negedge clk);
    check("ch0_second_done", done, 5'b00001);
    repeat (3) @(negedge clk);
    check("ch3_done", done, 5'b01000);
    check("all_idle_t4", busy, 0);
    exp_pos[0] = 32'd4;
    exp_pos[3] = 32'hFFFF_FFFD;
    check_pos("concurrent");

    // Channel 4: abort on the tenth rising edge.
    send(4, CNT_W'(100), DIV_W'(8), 1'b1);
    edges = 0; prev = 1'b0; cyc10 = -1;
    for (int k = 1; k < 300; k++) begin
      @(negedge clk);
      if (step[4] && !prev) edges++;
      prev = step[4];
      if (edges == 10) begin
        cyc10 = k;
        break;
      end
    end
    check("ch4_tenth_edge_cycle", cyc10, 75);
    abort[4] = 1'b1;
    @(negedge clk);
    check("ch4_abort_step", step[4], 0);
    check("ch4_abort_busy", busy[4], 0);
    abort[4] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      seen |= done[4];
      if (step[4] && !prev) edges++;
      prev = step[4];
    end
    check("ch4_no_done", seen, 0);
    check("ch4_edge_total", edges, 10);
    exp_pos[4] = 32'd10;
    check_pos("abort");

    // Abort coinciding with accept drops the command.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_chan = 3'd2; cmd_steps = CNT_W'(4); cmd_period = DIV_W'(3); cmd_dir = 1'b0;
    abort[2] = 1'b1;
    #1 check("ready_abort_accept", cmd_ready, 1);
    @(posedge clk);
    #1 begin cmd_valid = 1'b0; abort[2] = 1'b0; end
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      seen |= step[2] | busy[2] | done[2];
    end
    check("ch2_dropped_activity", seen, 0);
    check("ch2_dropped_dir", dir[2], 1);

    // Channel 1: maximum step count, clear position on a rising-edge cycle, then abort.
    send(1, '1, DIV_W'(3), 1'b1);
    repeat (20) @(negedge clk);
    check("ch1_max_busy", busy[1], 1);
    check("ch1_max_low", step[1], 0);
`ifdef STEPPER_POS_EN
    pos_clr[1] = 1'b1;
`endif
    @(negedge clk);
`ifdef STEPPER_POS_EN
    pos_clr[1] = 1'b0;
`endif
    check("ch1_max_rise", step[1], 1);
    exp_pos[1] = '0;
    check_pos("clr_priority");
    abort[1] = 1'b1;
    @(negedge clk);
    abort[1] = 1'b0;
    check("ch1_max_abort", {step[1], busy[1]}, 0);

    // Out-of-range channel is consumed with no effect.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_chan = 3'd7; cmd_steps = CNT_W'(5); cmd_period = DIV_W'(3); cmd_dir = 1'b0;
    #1 check("ready_chan7", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seen |= (|busy) | (|step) | (|done);
    end
    check("chan7_no_activity", seen, 0);
    check("chan7_dir_unchanged", dir, 5'b10110);
    check_pos("chan7");

    // Asynchronous reset mid-move.
    send(0, CNT_W'(10), DIV_W'(5), 1'b1);
    repeat (6) @(negedge clk);
    check("pre_reset_busy_dir", {busy[0], dir[0]}, 2'b11);
    #2 reset_n = 1'b0;
    #1 check("async_reset_outputs", {step, dir, busy, done}, 0);
    for (int c = 0; c < CH; c++) exp_pos[c] = '0;
    check_pos("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stepper_pulse_gen.md
Name: stepper_pulse_gen

Overview:
- Multi-channel stepper step/direction pulse generator. Replaces the single-channel clk_gen-based stepper control.
- Accepts move commands per channel over a valid/ready handshake. Each command carries a step count, a step period and a direction.
- Each channel runs its own state machine, producing dir and step outputs with a programmable direction setup time, pulse width, and per-channel busy/done status.
- Sits between the motion command decoder and the stepper driver pins.

Parameters:
- CHANNELS, 5, number of independent stepper channels (1..16).
- CNT_W, 31, step count width.
- DIV_W, 32, step period width, in clk cycles.
- PULSE_W, 2, step high time in clk cycles (>=1).
- DIR_SETUP, 2, cycles between dir update and the first step rising edge (>=1).
- POS_W, 32, position counter width (STEPPER_POS_EN only).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_chan  in  $clog2(CHANNELS) (min 1)  target channel.
- cmd_steps  in  CNT_W  number of steps.
- cmd_period  in  DIV_W  clocks per step.
- cmd_dir  in  1  direction (1 = positive).
- abort  in  CHANNELS  per-channel stop request.
- step  out  CHANNELS  step pulses, registered.
- dir  out  CHANNELS  direction, registered.
- busy  out  CHANNELS  channel executing a command.
- done  out  CHANNELS  one-cycle pulse on normal completion.
- pos  out  CHANNELS*POS_W  signed positions, channel 0 in the LSBs (STEPPER_POS_EN only).
- pos_clr  in  CHANNELS  per-channel position clear (STEPPER_POS_EN only).

Behaviour:
- Reset: step, dir, busy and done all 0; every FSM in IDLE; counters 0; pos 0.
- cmd_ready is combinational: equals !busy[cmd_chan]. It is forced to 1 when cmd_chan >= CHANNELS; such commands are consumed and discarded.
- Accept occurs in cycle N when cmd_valid && cmd_ready. In cycle N+1: busy=1, dir=cmd_dir, and steps/period are latched.
- Effective period is max(cmd_period, PULSE_W+1).
- Per-channel FSM states: IDLE, SETUP, HIGH, LOW, FIN.
  - IDLE -> SETUP on accept with steps > 0. IDLE -> FIN on accept with steps == 0 (no step is produced).
  - SETUP lasts DIR_SETUP cycles, then -> HIGH. The first rising edge of step is at cycle N+1+DIR_SETUP.
  - HIGH: step=1 for PULSE_W cycles. The remaining-step counter decrements on entry. Then -> LOW.
  - LOW: step=0 for period-PULSE_W cycles. Then -> HIGH if remaining > 0, else -> FIN.
  - FIN: one cycle with done=1 and busy=0, then -> IDLE. A new command is acceptable in the FIN cycle.
- Step rising edges are spaced exactly by the effective period. Counters never wrap; cmd_steps = 2^CNT_W-1 is legal.
- abort[i] (sampled each cycle):
  - Next cycle the FSM goes to IDLE with step=0 and busy=0; done is not pulsed.
  - A truncated high pulse is permitted.
  - Abort in IDLE has no effect.
  - Abort in the same cycle as an accept on that channel: the abort wins and the command is dropped, though it still counts as handshaken.
- Channels are fully independent; simultaneous completions are all reported in the same cycle.
- dir changes only on accept, never mid-move.

Optional Feature:
- STEPPER_POS_EN defined:
  - pos ports are present.
  - Each step rising edge adds +1 (dir=1) or -1 (dir=0) to that channel's two's-complement POS_W counter, which wraps modulo 2^POS_W.
  - pos_clr[i] zeroes the counter and takes priority over a same-cycle step.
- STEPPER_POS_EN undefined: pos/pos_clr ports and all position logic are absent; the other behaviour is identical.

Test Plan:
- Defaults. Ch0: steps=3, period=10, dir=1, accepted cycle 0. Expected: busy 1 from cycle 1; step high cycles 3-4, 13-14, 23-24; done pulse and busy=0 at cycle 33; pos[0]=3.
- Ch2: steps=0, period=10. Expected: no step edge; done[2] at cycle 1 for one cycle; busy[2] stays 0 except... never set.
- Ch1: steps=5, period=1. Expected: effective period 3 cycles; five rising edges spaced 3 apart; dir=0 gives pos[1] = -5.
- Ch0 busy, then cmd to ch0 then ch3 on consecutive cycles. Expected: cmd_ready=0 for ch0 until its FIN cycle; the ch3 command is accepted immediately; both run concurrently.
- Ch4 running steps=100, period=8; abort[4] asserted at the 10th rising edge. Expected: next cycle step=0 and busy=0; no done; exactly 10 edges counted.
- cmd_chan=7 with CHANNELS=5. Expected: cmd_ready=1 and no channel state changes. Also: reset_n pulsed low mid-move forces all outputs to 0 immediately (asynchronous).
